// File: rtl/tritone_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tritone_dmem_arbiter
// Purpose  : Single-port DMEM arbiter between the ternary CPU load/store port
//            and the TPU DMA bridge. Grants one SRAM access per cycle, returns
//            read data one cycle after the grant to whichever master owns the
//            read, and packs/unpacks trits for the 32-bit DMA side.
//            A starvation counter forces a DMA grant after STARVE_LIMIT
//            consecutive denied DMA cycles.
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            cpu_*_i / cpu_*_o    - CPU request/grant/read-return channel
//            dma_*_i / dma_*_o    - DMA request/grant/read-return channel
//            mem_*_o / mem_rdata_i- shared SRAM port (1-cycle read latency)
//            conflict_cnt_o       - saturating count of dual-request cycles
//            enc_err_o            - sticky invalid-trit flag
// Config   : DMEM_ENC_CHECK_EN    - when defined, written trits equal to 2'b11
//                                   are stored as T_ZERO and set enc_err_o.
// Revision : 1.0 - initial release
// ============================================================================
module tritone_dmem_arbiter #(
  parameter int TRIT_WIDTH   = 27,
  parameter int DMEM_DEPTH   = 2048,
  parameter int ADDR_BITS    = 11,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_req_i,
  input  logic                    cpu_we_i,
  input  logic [ADDR_BITS-1:0]    cpu_addr_i,
  input  logic [2*TRIT_WIDTH-1:0] cpu_wdata_i,
  output logic                    cpu_gnt_o,
  output logic                    cpu_rvalid_o,
  output logic [2*TRIT_WIDTH-1:0] cpu_rdata_o,
  input  logic                    dma_req_i,
  input  logic                    dma_we_i,
  input  logic [ADDR_BITS-1:0]    dma_addr_i,
  input  logic [31:0]             dma_wdata_i,
  output logic                    dma_gnt_o,
  output logic                    dma_rvalid_o,
  output logic [31:0]             dma_rdata_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [ADDR_BITS-1:0]    mem_addr_o,
  output logic [2*TRIT_WIDTH-1:0] mem_wdata_o,
  input  logic [2*TRIT_WIDTH-1:0] mem_rdata_i,
  output logic [15:0]             conflict_cnt_o,
  output logic                    enc_err_o
);

  localparam int C_DW = 2 * TRIT_WIDTH;
  localparam int C_SW = $clog2(STARVE_LIMIT + 1);
  // One extra bit so an out-of-range test also works when DEPTH == 2**ADDR_BITS.
  localparam logic [ADDR_BITS:0] C_DEPTH       = (ADDR_BITS + 1)'(DMEM_DEPTH);
  localparam logic [C_SW-1:0]    C_STARVE_LAST = C_SW'(STARVE_LIMIT - 1);
  localparam logic [1:0]         C_T_ZERO      = 2'b00;
  localparam logic [1:0]         C_T_BAD       = 2'b11;

  typedef enum logic [0:0] {
    CPU_PRI   = 1'b0,
    DMA_FORCE = 1'b1
  } state_t;

  state_t            state_q;
  logic [C_SW-1:0]   starve_q;
  logic              rd_cpu_q, rd_cpu_d;
  logic              rd_dma_q, rd_dma_d;
  logic              rd_oor_q, rd_oor_d;
  logic [15:0]       conflict_q, conflict_d;

  logic              w_cpu_gnt, w_dma_gnt;
  logic              w_cpu_in, w_dma_in;
  logic [C_DW-1:0]   w_cpu_wd, w_dma_wd;

  function automatic logic [1:0] f_sanitize(input logic [1:0] t);
`ifdef DMEM_ENC_CHECK_EN
    return (t == C_T_BAD) ? C_T_ZERO : t;
`else
    return t;
`endif
  endfunction

  // --------------------------------------------------------------------------
  // Arbitration: grants are gated by rst_n so every output is 0 in reset.
  // --------------------------------------------------------------------------
  assign w_dma_gnt = rst_n && dma_req_i && ((state_q == DMA_FORCE) || !cpu_req_i);
  assign w_cpu_gnt = rst_n && cpu_req_i && !w_dma_gnt;
  assign cpu_gnt_o = w_cpu_gnt;
  assign dma_gnt_o = w_dma_gnt;

  assign w_cpu_in  = ({1'b0, cpu_addr_i} < C_DEPTH);
  assign w_dma_in  = ({1'b0, dma_addr_i} < C_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CPU_PRI;
      starve_q <= '0;
    end else begin
      case (state_q)
        CPU_PRI: begin
          if (w_dma_gnt) begin
            starve_q <= '0;
          end else if (dma_req_i) begin
            starve_q <= starve_q + C_SW'(1);
            if (starve_q == C_STARVE_LAST) begin
              state_q <= DMA_FORCE;
            end
          end
        end
        // DMA either takes its forced grant now or has withdrawn; both
        // outcomes return to CPU priority with a cleared counter.
        DMA_FORCE: begin
          starve_q <= '0;
          state_q  <= CPU_PRI;
        end
        default: begin
          starve_q <= '0;
          state_q  <= CPU_PRI;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Write data: CPU word passes through, DMA fills trits 0..15 and zeroes the rest
  // --------------------------------------------------------------------------
`ifdef DMEM_ENC_CHECK_EN
  logic [TRIT_WIDTH-1:0] w_cpu_bad, w_dma_bad;
`endif

  for (genvar i = 0; i < TRIT_WIDTH; i++) begin : g_trit
    logic [1:0] w_dma_t;
    if (i < 16) begin : g_dma_lo
      assign w_dma_t = dma_wdata_i[2*i +: 2];
    end else begin : g_dma_hi
      assign w_dma_t = C_T_ZERO;
    end
    assign w_cpu_wd[2*i +: 2] = f_sanitize(cpu_wdata_i[2*i +: 2]);
    assign w_dma_wd[2*i +: 2] = f_sanitize(w_dma_t);
`ifdef DMEM_ENC_CHECK_EN
    assign w_cpu_bad[i] = (cpu_wdata_i[2*i +: 2] == C_T_BAD);
    assign w_dma_bad[i] = (w_dma_t == C_T_BAD);
`endif
  end

  // --------------------------------------------------------------------------
  // SRAM port: out-of-range accesses are granted but never reach the SRAM
  // --------------------------------------------------------------------------
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (w_dma_gnt && w_dma_in) begin
      mem_en_o    = 1'b1;
      mem_we_o    = dma_we_i;
      mem_addr_o  = dma_addr_i;
      mem_wdata_o = dma_we_i ? w_dma_wd : '0;
    end else if (w_cpu_gnt && w_cpu_in) begin
      mem_en_o    = 1'b1;
      mem_we_o    = cpu_we_i;
      mem_addr_o  = cpu_addr_i;
      mem_wdata_o = cpu_we_i ? w_cpu_wd : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Read-return tag and conflict counter
  // --------------------------------------------------------------------------
  always_comb begin
    rd_cpu_d   = w_cpu_gnt && !cpu_we_i;
    rd_dma_d   = w_dma_gnt && !dma_we_i;
    rd_oor_d   = (rd_cpu_d && !w_cpu_in) || (rd_dma_d && !w_dma_in);
    conflict_d = conflict_q;
    if (cpu_req_i && dma_req_i && (conflict_q != 16'hFFFF)) begin
      conflict_d = conflict_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cpu_q   <= 1'b0;
      rd_dma_q   <= 1'b0;
      rd_oor_q   <= 1'b0;
      conflict_q <= '0;
    end else begin
      rd_cpu_q   <= rd_cpu_d;
      rd_dma_q   <= rd_dma_d;
      rd_oor_q   <= rd_oor_d;
      conflict_q <= conflict_d;
    end
  end

  assign cpu_rvalid_o   = rd_cpu_q;
  assign dma_rvalid_o   = rd_dma_q;
  assign cpu_rdata_o    = (rd_cpu_q && !rd_oor_q) ? mem_rdata_i : '0;
  assign dma_rdata_o    = (rd_dma_q && !rd_oor_q) ? mem_rdata_i[31:0] : '0;
  assign conflict_cnt_o = conflict_q;

`ifdef DMEM_ENC_CHECK_EN
  logic enc_err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_err_q <= 1'b0;
    end else if ((w_cpu_gnt && cpu_we_i && (|w_cpu_bad)) ||
                 (w_dma_gnt && dma_we_i && (|w_dma_bad))) begin
      enc_err_q <= 1'b1;
    end
  end
  assign enc_err_o = enc_err_q;
`else
  assign enc_err_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tritone_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tritone_dmem_arbiter
// Purpose  : Directed self-checking bench for tritone_dmem_arbiter with a
//            behavioural SRAM, a shadow memory and read-return scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tritone_dmem_arbiter;

  localparam int C_TW = 27;
  localparam int C_DW = 54;
  localparam int C_AW = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [C_AW-1:0]   cpu_addr = '0;
  logic [C_DW-1:0]   cpu_wdata = '0;
  logic              cpu_gnt, cpu_rvalid;
  logic [C_DW-1:0]   cpu_rdata;
  logic              dma_req = 1'b0, dma_we = 1'b0;
  logic [C_AW-1:0]   dma_addr = '0;
  logic [31:0]       dma_wdata = '0;
  logic              dma_gnt, dma_rvalid;
  logic [31:0]       dma_rdata;
  logic              mem_en, mem_we;
  logic [C_AW-1:0]   mem_addr;
  logic [C_DW-1:0]   mem_wdata;
  logic [C_DW-1:0]   mem_rdata = '0;
  logic [15:0]       conflict_cnt;
  logic              enc_err;

  int checks = 0;
  int failures = 0;
  int exp_conf = 0;
  logic exp_enc = 1'b0;

  logic [C_DW-1:0] sram   [2048];
  logic [C_DW-1:0] shadow [2048];
  logic [C_DW-1:0] cpu_q [$];
  logic [31:0]     dma_q [$];

  always #5 clk = ~clk;

  tritone_dmem_arbiter #(
    .TRIT_WIDTH(C_TW), .DMEM_DEPTH(2048), .ADDR_BITS(C_AW), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid),
    .cpu_rdata_o(cpu_rdata),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr),
    .dma_wdata_i(dma_wdata), .dma_gnt_o(dma_gnt), .dma_rvalid_o(dma_rvalid),
    .dma_rdata_o(dma_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .conflict_cnt_o(conflict_cnt), .enc_err_o(enc_err)
  );

  // Behavioural single-port SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) sram[mem_addr[10:0]] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr[10:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [C_DW-1:0] san(input logic [C_DW-1:0] w);
    logic [C_DW-1:0] r;
    r = w;
`ifdef DMEM_ENC_CHECK_EN
    for (int i = 0; i < C_TW; i++) if (w[2*i +: 2] == 2'b11) r[2*i +: 2] = 2'b00;
`endif
    return r;
  endfunction

  function automatic logic has_bad(input logic [C_DW-1:0] w);
    logic b;
    b = 1'b0;
    for (int i = 0; i < C_TW; i++) if (w[2*i +: 2] == 2'b11) b = 1'b1;
    return b;
  endfunction

  // Read-return scoreboard: every expected entry must come out on the cycle
  // right after its grant; no rvalid is allowed without a pending entry.
  always begin
    @(posedge clk);
    #2;
    check("cpu_rvalid", cpu_rvalid, cpu_q.size() != 0);
    if (cpu_q.size() != 0) check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
    check("dma_rvalid", dma_rvalid, dma_q.size() != 0);
    if (dma_q.size() != 0) check("dma_rdata", dma_rdata, dma_q.pop_front());
  end

  // One directed cycle: drive, check grants/SRAM/status at negedge, update model.
  task automatic step(input logic creq, input logic cwe, input logic [C_AW-1:0] ca,
                      input logic [C_DW-1:0] cwd, input logic dreq, input logic dwe,
                      input logic [C_AW-1:0] da, input logic [31:0] dwd,
                      input logic ecg, input logic edg, input string tag);
    logic exp_en;
    cpu_req = creq; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
    dma_req = dreq; dma_we = dwe; dma_addr = da; dma_wdata = dwd;
    @(negedge clk);
    exp_en = (ecg && ca < 2048) || (edg && da < 2048);
    check({tag, ".cpu_gnt"}, cpu_gnt, ecg);
    check({tag, ".dma_gnt"}, dma_gnt, edg);
    check({tag, ".mem_en"}, mem_en, exp_en);
    check({tag, ".conflict_cnt"}, conflict_cnt, exp_conf);
    check({tag, ".enc_err"}, enc_err, exp_enc);
    if (creq && dreq && exp_conf < 16'hFFFF) exp_conf++;
    if (ecg) begin
      if (cwe) begin
        if (ca < 2048) shadow[ca[10:0]] = san(cwd);
`ifdef DMEM_ENC_CHECK_EN
        if (has_bad(cwd)) exp_enc = 1'b1;
`endif
      end else begin
        cpu_q.push_back(ca < 2048 ? shadow[ca[10:0]] : '0);
      end
    end
    if (edg) begin
      if (dwe) begin
        if (da < 2048) shadow[da[10:0]] = san({22'd0, dwd});
`ifdef DMEM_ENC_CHECK_EN
        if (has_bad({22'd0, dwd})) exp_enc = 1'b1;
`endif
      end else begin
        dma_q.push_back(da < 2048 ? shadow[da[10:0]][31:0] : 32'd0);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, tag);
  endtask

  localparam logic [C_DW-1:0] C_D = 54'h2_4924_9249_2492;
  localparam logic [C_DW-1:0] C_E = 54'h1_8421_0842_1084;

  initial begin
    for (int i = 0; i < 2048; i++) begin
      sram[i] = '0;
      shadow[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst.cpu_gnt", cpu_gnt, 1'b0);
    check("rst.mem_en", mem_en, 1'b0);
    check("rst.conflict", conflict_cnt, 16'd0);
    check("rst.enc_err", enc_err, 1'b0);
    rst_n = 1'b1;

    // CPU write then read back
    step(1, 1, 12'h005, C_D, 0, 0, '0, '0, 1, 0, "t1.wr");
    step(1, 0, 12'h005, '0,  0, 0, '0, '0, 1, 0, "t1.rd");
    idle("t1.idle");

    // Both masters reading every cycle: C,C,C,C,D repeating
    for (int k = 0; k < 10; k++) begin
      step(1, 0, 12'h005, '0, 1, 0, 12'h005, '0, (k % 5) != 4, (k % 5) == 4, "t2");
    end
    idle("t2.idle");

    // DMA write of one trit, CPU reads full word
    step(0, 0, '0, '0, 1, 1, 12'h010, 32'h0000_0001, 0, 1, "t3.wr");
    step(1, 0, 12'h010, '0, 0, 0, '0, '0, 1, 0, "t3.rd");
    idle("t3.idle");

    // Address boundaries for DMA reads and a dropped CPU write
    step(1, 1, 12'h7FF, C_E, 0, 0, '0, '0, 1, 0, "t4.wrmax");
    step(0, 0, '0, '0, 1, 0, 12'h7FF, '0, 0, 1, "t4.rdmax");
    step(0, 0, '0, '0, 1, 0, 12'h800, '0, 0, 1, "t4.rdoor");
    step(1, 1, 12'h800, C_D, 0, 0, '0, '0, 1, 0, "t4.wroor");
    step(1, 0, 12'h800, '0, 0, 0, '0, '0, 1, 0, "t4.cpurdoor");
    idle("t4.idle");

    // Unused trit code via DMA
    step(0, 0, '0, '0, 1, 1, 12'h020, 32'h0000_0003, 0, 1, "t6.wr");
    step(1, 0, 12'h020, '0, 0, 0, '0, '0, 1, 0, "t6.rd");
    idle("t6.idle1");
    idle("t6.idle2");

    // Reset during the cycle after a CPU read grant
    step(1, 0, 12'h005, '0, 0, 0, '0, '0, 1, 0, "t5.rd");
    rst_n = 1'b0;
    cpu_q.delete();
    dma_q.delete();
    cpu_req = 1'b1;
    dma_req = 1'b1;
    @(negedge clk);
    check("t5.cpu_gnt", cpu_gnt, 1'b0);
    check("t5.dma_gnt", dma_gnt, 1'b0);
    check("t5.cpu_rvalid", cpu_rvalid, 1'b0);
    check("t5.cpu_rdata", cpu_rdata, '0);
    check("t5.dma_rdata", dma_rdata, '0);
    check("t5.mem_en", mem_en, 1'b0);
    check("t5.mem_we", mem_we, 1'b0);
    check("t5.mem_addr", mem_addr, '0);
    check("t5.mem_wdata", mem_wdata, '0);
    check("t5.conflict", conflict_cnt, 16'd0);
    check("t5.enc_err", enc_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    rst_n = 1'b1;
    exp_conf = 0;
    exp_enc = 1'b0;
    idle("t5.idle");
    step(1, 0, 12'h005, '0, 0, 0, '0, '0, 1, 0, "t5.post");
    idle("t5.flush");
    check("end.cpu_q_empty", cpu_q.size(), 0);
    check("end.dma_q_empty", dma_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
